// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between three writeback sources
//   (0 = load, 1 = ALU, 2 = mult/div). One write is granted per cycle by fixed
//   priority (0 > 1 > 2), and aging keeps a stalled source from starving. The
//   winning write is registered toward the register file. A scoreboard of
//   destinations with writes still pending lets the issue stage stall.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   req_valid[2:0]   per-source write request
//   req_addr[14:0]   destination register, 5 bits per source
//   req_data[95:0]   write data, 32 bits per source
//   req_ready[2:0]   combinational grant, one-hot or zero
//   write            registered register-file write enable
//   write_addr[4:0]  registered write address
//   data_in[31:0]    registered write data
//   rsv_valid        issue stage reserves a destination this cycle
//   rsv_addr[4:0]    destination being reserved
//   busy             scoreboard, bit r = register r has a write pending
module wb_port_arbiter #(
  parameter int AGE_LIMIT = 4,
  parameter int NUM_REGS  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req_valid,
  input  logic [14:0]         req_addr,
  input  logic [95:0]         req_data,
  output logic [2:0]          req_ready,
  output logic                write,
  output logic [4:0]          write_addr,
  output logic [31:0]         data_in,
  input  logic                rsv_valid,
  input  logic [4:0]          rsv_addr,
  output logic [NUM_REGS-1:0] busy
);

  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

  logic [3:0]          age [3];
  logic [2:0]          urgent;
  logic [2:0]          pool;
  logic                accept;
  logic [4:0]          sel_addr;
  logic [31:0]         sel_data;
  logic [NUM_REGS-1:0] busy_next;

  // Urgent requesters form the candidate pool when any exist; the lowest set
  // bit of the pool is the fixed-priority winner.
  always_comb begin
    urgent = '0;
    for (int i = 0; i < 3; i++)
      urgent[i] = req_valid[i] && (age[i] == AGE_MAX);
    pool      = (|urgent) ? urgent : req_valid;
    req_ready = pool & 3'(~pool + 3'd1);
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
    end
    accept = |req_ready;
  end

  // A write to register 0 is accepted but swallowed: no write strobe, and the
  // last address/data are left in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write      <= 1'b0;
      write_addr <= '0;
      data_in    <= '0;
      for (int i = 0; i < 3; i++)
        age[i] <= '0;
    end else begin
      write <= accept && (sel_addr != 5'd0);
      if (accept && (sel_addr != 5'd0)) begin
        write_addr <= sel_addr;
        data_in    <= sel_data;
      end
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || req_ready[i])
          age[i] <= '0;
        else if (age[i] < AGE_MAX)
          age[i] <= age[i] + 4'd1;
      end
    end
  end

  // Clear is applied before set so a reservation landing on the register being
  // written keeps it busy for the newer pending write.
  always_comb begin
    busy_next = busy;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (write && (write_addr == 5'(r)))
        busy_next[r] = 1'b0;
      if (rsv_valid && (rsv_addr == 5'(r)))
        busy_next[r] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_next;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        write;
  logic [4:0]  write_addr;
  logic [31:0] data_in;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.AGE_LIMIT(4), .NUM_REGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .write      (write),
    .write_addr (write_addr),
    .data_in    (data_in),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_write", 32'(write), 32'd0);
    check("rst_addr", 32'(write_addr), 32'd0);
    check("rst_data", data_in, 32'd0);
    check("rst_busy", busy, 32'd0);

    // single ALU write
    req_valid = 3'b010;
    req_addr[9:5] = 5'd5;
    req_data[63:32] = 32'hDEADBEEF;
    #1 check("single_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("single_write", 32'(write), 32'd1);
    check("single_waddr", 32'(write_addr), 32'd5);
    check("single_wdata", data_in, 32'hDEADBEEF);
    tick();
    check("single_idle", 32'(write), 32'd0);

    // priority and aging: source 2 stalls four cycles then wins on urgency
    for (int c = 0; c < 5; c++) begin
      req_valid = 3'b101;
      req_addr[4:0] = 5'(c + 1);
      req_data[31:0] = 32'hA000_0000 + 32'(c);
      req_addr[14:10] = 5'd20;
      req_data[95:64] = 32'h2222_2222;
      #1 check($sformatf("age_ready%0d", c), 32'(req_ready), (c == 4) ? 32'h4 : 32'h1);
      tick();
      if (c == 4) req_valid = '0;
      check($sformatf("age_write%0d", c), 32'(write), 32'd1);
      check($sformatf("age_waddr%0d", c), 32'(write_addr), (c == 4) ? 32'd20 : 32'(c + 1));
      check($sformatf("age_wdata%0d", c), data_in, (c == 4) ? 32'h2222_2222 : 32'hA000_0000 + 32'(c));
    end
    tick();
    check("age_idle", 32'(write), 32'd0);

    // scoreboard round trip on r7
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    rsv_valid = 1'b0;
    check("sb_set", busy, 32'h80);
    req_valid = 3'b010;
    req_addr[9:5] = 5'd7;
    req_data[63:32] = 32'h0000_0077;
    #1 check("sb_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("sb_write", 32'(write), 32'd1);
    check("sb_busy_during", busy, 32'h80);
    tick();
    check("sb_busy_after", busy, 32'h0);

    // set/clear collision on r9
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    tick();
    rsv_valid = 1'b0;
    check("col_set", busy, 32'h200);
    req_valid = 3'b010;
    req_addr[9:5] = 5'd9;
    req_data[63:32] = 32'h0000_0099;
    tick();
    req_valid = '0;
    check("col_write", 32'(write), 32'd1);
    check("col_waddr", 32'(write_addr), 32'd9);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    tick();
    rsv_valid = 1'b0;
    check("col_busy", busy, 32'h200);
    check("col_idle", 32'(write), 32'd0);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    tick();
    check("col_clear", busy, 32'h0);

    // register 0: accepted, no write, no busy
    req_valid = 3'b001;
    req_addr[4:0] = 5'd0;
    req_data[31:0] = 32'h1234_5678;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd0;
    #1 check("r0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    rsv_valid = 1'b0;
    check("r0_write", 32'(write), 32'd0);
    check("r0_busy", busy, 32'h0);

    // asynchronous reset mid-cycle while a write is in flight
    rsv_valid = 1'b1;
    rsv_addr  = 5'd4;
    tick();
    rsv_valid = 1'b0;
    req_valid = 3'b010;
    req_addr[9:5] = 5'd4;
    req_data[63:32] = 32'h0000_0044;
    tick();
    req_valid = '0;
    check("pre_rst_write", 32'(write), 32'd1);
    check("pre_rst_busy", busy, 32'h10);
    #3 reset = 1'b1;
    #1;
    check("arst_write", 32'(write), 32'd0);
    check("arst_busy", busy, 32'h0);
    check("arst_waddr", 32'(write_addr), 32'd0);
    check("arst_wdata", data_in, 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    #1 reset = 1'b0;
    tick();

    // reset clears age counters: source 2 aged to urgent, then reset
    req_valid = 3'b101;
    req_addr[4:0] = 5'd1;
    req_addr[14:10] = 5'd2;
    for (int c = 0; c < 4; c++) tick();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("arst_age", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
